// File: rtl/echo_pkg.sv
// Shared types for the echo requester: FSM state, scoreboard entry, counter helper.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One outstanding request as the responder must echo it back.
  typedef struct packed {
    logic [31:0] meth;
    logic [31:0] v;
  } expect_t;

  // Saturating 16-bit increment for the pass/error counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/echo_expect_fifo.sv
// Scoreboard of outstanding requests: small synchronous FIFO of expect_t.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module echo_expect_fifo
  import echo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    CLK,
  input  logic    nRST,
  input  logic    flush,
  input  logic    push,
  input  expect_t push_data,
  input  logic    pop,
  output expect_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  expect_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer/occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/echo_requester.sv
// Initiator side of the echo loopback: issues say/say2 alternately, scoreboards
// every heard reply against the expected {meth, v}, reports pass/err/done/timeout.
module echo_requester
  import echo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int STRIDE   = 3,
  parameter int MAX_WAIT = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] count,
  input  logic [31:0] seed,
  output logic        request_say__ENA,
  output logic [31:0] request_say_meth,
  output logic [31:0] request_say_v,
  input  logic        request_say__RDY,
  output logic        request_say2__ENA,
  output logic [31:0] request_say2_meth,
  output logic [31:0] request_say2_v,
  input  logic        request_say2__RDY,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_meth,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] pass_count,
  output logic [15:0] err_count
);

  localparam int          WW        = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_e        state_q, state_d;
  logic [15:0]   i_q, i_d;          // index of the next request to issue
  logic [15:0]   cnt_q, cnt_d;      // requests in this run
  logic [31:0]   v_q, v_d;          // running payload, seed + i*STRIDE
  logic [15:0]   pass_q, pass_d;
  logic [15:0]   err_q, err_d;
  logic          timeout_q, timeout_d;
  logic [WW-1:0] wait_q, wait_d;    // idle DRAIN cycles since entry or last reply

  expect_t sb_head;
  logic    sb_full, sb_empty;
  logic    accept_start, active, want, say_fire, say2_fire, fire;
  logic    heard_rdy, heard_fire, heard_match, wait_expired;

  assign accept_start = start && (state_q == IDLE || state_q == DONE);
  assign active       = (state_q == RUN) || (state_q == DRAIN);
  assign want         = (state_q == RUN) && (i_q < cnt_q) && !sb_full;
  assign say_fire     = want && !i_q[0] && request_say__RDY;
  assign say2_fire    = want &&  i_q[0] && request_say2__RDY;
  assign fire         = say_fire || say2_fire;
  assign heard_rdy    = active && !sb_empty;
  assign heard_fire   = indication_heard__ENA && heard_rdy;
  assign heard_match  = (sb_head == {indication_heard_meth, indication_heard_v});
  assign wait_expired = (state_q == DRAIN) && !sb_empty && !heard_fire && (wait_q == WAIT_LAST);

  echo_expect_fifo #(.DEPTH(DEPTH)) u_sb (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (accept_start),
    .push      (fire),
    .push_data ({16'h0, i_q, v_q}),
    .pop       (heard_fire),
    .head      (sb_head),
    .full      (sb_full),
    .empty     (sb_empty)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: run until all issued, then drain until empty or idle too long.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept_start) state_d = (count == 16'd0) ? DONE : RUN;
      RUN:        if (i_q == cnt_q) state_d = DRAIN;
      DRAIN:      if (sb_empty || wait_expired) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: status flags and request channels; payload is zero unless issuing is wanted.
  always_comb begin
    busy                  = active;
    done                  = (state_q == DONE);
    request_say__ENA      = say_fire;
    request_say2__ENA     = say2_fire;
    request_say_meth      = want ? {16'h0, i_q} : 32'h0;
    request_say_v         = want ? v_q : 32'h0;
    request_say2_meth     = want ? {16'h0, i_q} : 32'h0;
    request_say2_v        = want ? v_q : 32'h0;
    indication_heard__RDY = heard_rdy;
    timeout               = timeout_q;
    pass_count            = pass_q;
    err_count             = err_q;
  end

  // Datapath next values: issue index, payload, counters, wait timer.
  always_comb begin
    i_d       = i_q;
    cnt_d     = cnt_q;
    v_d       = v_q;
    pass_d    = pass_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    wait_d    = wait_q;
    if (accept_start) begin
      i_d       = '0;
      cnt_d     = count;
      v_d       = seed;
      pass_d    = '0;
      err_d     = '0;
      timeout_d = 1'b0;
      wait_d    = '0;
    end else begin
      if (fire) begin
        i_d = i_q + 16'd1;
        v_d = v_q + 32'(STRIDE);
      end
      if (heard_fire) begin
        if (heard_match) pass_d = sat_inc(pass_q);
        else             err_d  = sat_inc(err_q);
      end
      // Outside DRAIN the timer sits at zero, so DRAIN always starts from a fresh count.
      if (state_q != DRAIN || heard_fire) wait_d = '0;
      else if (wait_q != WAIT_LAST)       wait_d = wait_q + 1'b1;
      if (wait_expired) timeout_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      i_q       <= '0;
      cnt_q     <= '0;
      v_q       <= '0;
      pass_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      i_q       <= i_d;
      cnt_q     <= cnt_d;
      v_q       <= v_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_echo_requester.sv
// Randomized loopback bench for echo_requester with a queue-based responder
// and an arithmetic reference of the request stream and reply scoring.
module tb_echo_requester;

  localparam int DEPTH    = 4;
  localparam int STRIDE   = 3;
  localparam int MAX_WAIT = 1024;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic [31:0] seed = '0;
  logic        say_ena, say2_ena, h_rdy, busy, done, timeout;
  logic        say_rdy = 1'b0, say2_rdy = 1'b0, h_ena = 1'b0;
  logic [31:0] say_meth, say_v, say2_meth, say2_v;
  logic [31:0] h_meth = '0, h_v = '0;
  logic [15:0] pass_count, err_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          k;
    logic [31:0] m;
    logic [31:0] v;
  } req_t;

  always #5 CLK = ~CLK;

  echo_requester #(.DEPTH(DEPTH), .STRIDE(STRIDE), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .start                 (start),
    .count                 (count),
    .seed                  (seed),
    .request_say__ENA      (say_ena),
    .request_say_meth      (say_meth),
    .request_say_v         (say_v),
    .request_say__RDY      (say_rdy),
    .request_say2__ENA     (say2_ena),
    .request_say2_meth     (say2_meth),
    .request_say2_v        (say2_v),
    .request_say2__RDY     (say2_rdy),
    .indication_heard__ENA (h_ena),
    .indication_heard_meth (h_meth),
    .indication_heard_v    (h_v),
    .indication_heard__RDY (h_rdy),
    .busy                  (busy),
    .done                  (done),
    .timeout               (timeout),
    .pass_count            (pass_count),
    .err_count             (err_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":flags"}, {say_ena, say2_ena, h_rdy, busy, done, timeout}, 0);
    chk({tag, ":payload"}, say_meth | say_v | say2_meth | say2_v, 0);
    chk({tag, ":counts"}, {pass_count, err_count}, 0);
  endtask

  // One run: start, then per cycle drive responder, observe DUT, compare to the reference.
  // exp_gap > 0 requires done to appear exactly that many cycles after the last issue.
  task automatic run_test(input string nm, input int cnt, input logic [31:0] sd,
                          input int rdy_pct, input int rep_pct, input int corrupt_k,
                          input bit drop_last, input int rdy_low, input int silent,
                          input int restart_at, input int reset_at, input int exp_gap);
    req_t        rq[$];
    int          issued = 0, replied = 0, exp_pass = 0, exp_err = 0;
    int          last_iss = -1, done_cyc = -1, outst;
    bit          ew, efire;
    logic [31:0] gm, gv, ev;
    @(negedge CLK);
    start = 1'b1; count = 16'(cnt); seed = sd;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      say_rdy  = (cyc >= rdy_low) && ($urandom_range(99) < rdy_pct);
      say2_rdy = (cyc >= rdy_low) && ($urandom_range(99) < rdy_pct);
      h_ena = 1'b0; h_meth = $urandom; h_v = $urandom;
      if (rq.size() > 0 && cyc >= silent && $urandom_range(99) < rep_pct) begin
        h_ena  = 1'b1;
        h_meth = rq[0].m;
        h_v    = rq[0].v ^ ((rq[0].k == corrupt_k) ? 32'h100 : 32'h0);
      end
      if (cyc == restart_at) begin
        start = 1'b1; count = 16'(cnt + 7); seed = ~sd;
      end else start = 1'b0;
      if (cyc == reset_at) begin
        nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1; h_ena = 1'b0;
        #1;
        chk_all_zero({nm, ":after_reset"});
        return;
      end
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      outst = issued - replied;
      if (cyc == rdy_low && rdy_low > 0) chk({nm, ":no_issue_rdy_low"}, issued, 0);
      if (cyc == silent && silent > 0)
        chk({nm, ":stall_at_depth"}, issued, (cnt < DEPTH) ? cnt : DEPTH);
      chk({nm, ":busy"}, busy, 1);
      chk({nm, ":both_ena"}, say_ena & say2_ena, 0);
      chk({nm, ":pass_run"}, pass_count, 16'(exp_pass));
      chk({nm, ":err_run"}, err_count, 16'(exp_err));
      chk({nm, ":heard_rdy"}, h_rdy, outst > 0);
      ew    = (issued < cnt) && (outst < DEPTH);
      efire = ew && ((issued % 2 == 1) ? say2_rdy : say_rdy);
      chk({nm, ":fire"}, say_ena | say2_ena, efire);
      if (!ew) chk({nm, ":idle_payload"}, say_meth | say_v | say2_meth | say2_v, 0);
      if (say_ena | say2_ena) begin
        gm = say2_ena ? say2_meth : say_meth;
        gv = say2_ena ? say2_v : say_v;
        ev = sd + 32'(issued) * 32'(STRIDE);
        chk({nm, ":chan"}, say2_ena, issued % 2);
        chk({nm, ":meth"}, gm, 32'(issued));
        chk({nm, ":v"}, gv, ev);
        if (!(drop_last && issued == cnt - 1)) rq.push_back('{issued, gm, gv});
        issued++;
        last_iss = cyc;
      end
      if (h_ena && h_rdy) begin
        ev = sd + 32'(replied) * 32'(STRIDE);
        if (h_meth == 32'(replied) && h_v == ev) exp_pass++;
        else                                      exp_err++;
        replied++;
        void'(rq.pop_front());
      end
      @(negedge CLK);
    end
    start = 1'b0; h_ena = 1'b0;
    chk({nm, ":done_reached"}, done_cyc >= 0, 1);
    if (cnt == 0) chk({nm, ":done_latency"}, done_cyc, 0);
    if (exp_gap > 0) chk({nm, ":timeout_gap"}, done_cyc - last_iss, exp_gap);
    chk({nm, ":issued"}, issued, cnt);
    chk({nm, ":pass"}, pass_count, 16'(exp_pass));
    chk({nm, ":err"}, err_count, 16'(exp_err));
    chk({nm, ":timeout"}, timeout, drop_last);
    chk({nm, ":busy_end"}, busy, 0);
    chk({nm, ":heard_rdy_end"}, h_rdy, 0);
  endtask

  initial begin
    int c, rp, pp;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk_all_zero("reset");
    nRST = 1'b1;

    // T1: ideal loopback
    run_test("t1", 4, 32'h10, 100, 100, -1, 0, 0, 0, -1, -1, 0);
    chk("t1:pass_const", pass_count, 4);
    chk("t1:err_const", err_count, 0);
    chk("t1:done", done, 1);

    // T2: RDY low, then a silent responder fills the scoreboard, then release
    run_test("t2", 10, $urandom, 100, 100, -1, 0, 5, 25, -1, -1, 0);
    chk("t2:pass_const", pass_count, 10);

    // T3: corrupt reply 2
    run_test("t3", 5, $urandom, 100, 100, 2, 0, 0, 0, -1, -1, 0);
    chk("t3:pass_const", pass_count, 4);
    chk("t3:err_const", err_count, 1);

    // T4: last reply dropped -> idle DRAIN for MAX_WAIT cycles
    run_test("t4", 3, $urandom, 100, 100, -1, 1, 0, 0, -1, -1, MAX_WAIT + 2);
    chk("t4:pass_const", pass_count, 2);
    chk("t4:done", done, 1);

    // T5: empty run and a seed that wraps
    run_test("t5a", 0, $urandom, 100, 100, -1, 0, 0, 0, -1, -1, 0);
    run_test("t5b", 2, 32'hFFFF_FFFE, 100, 100, -1, 0, 0, 0, -1, -1, 0);

    // T6: start mid-run ignored, reset mid-run, rerun from IDLE
    run_test("t6a", 20, $urandom, 70, 70, -1, 0, 0, 0, 3, -1, 0);
    run_test("t6b", 20, $urandom, 70, 70, -1, 0, 0, 0, -1, 6, 0);
    run_test("t6c", 6, $urandom, 100, 100, -1, 0, 0, 0, -1, -1, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      c  = $urandom_range(40, 1);
      rp = $urandom_range(100, 30);
      pp = $urandom_range(100, 30);
      run_test("rnd", c, $urandom, rp, pp, $urandom_range(c + 3, 0), 0, 0, 0, -1, -1, 0);
    end

    // heard while not ready (state DONE) must be ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      h_ena = 1'b1; h_meth = $urandom; h_v = $urandom;
      #1;
      chk("ignore:heard_rdy", h_rdy, 0);
    end
    c = {16'h0, pass_count} + {16'h0, err_count};
    @(negedge CLK);
    h_ena = 1'b0;
    #1;
    chk("ignore:counts", {16'h0, pass_count} + {16'h0, err_count}, c);
    chk("ignore:done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
